// File: rtl/core_pkg.sv
// Shared definitions for the pipeline hazard logic: forward select codes,
// result-source encodings and the memory-wait state type.
package core_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Forward select for one EX source operand: the MEM result beats the WB result,
// and x0 is never forwarded.
module fwd_select
  import core_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m && (rd_m != 5'd0) && (rd_m == rs);
  assign hit_w = reg_write_w && (rd_w != 5'd0) && (rd_w == rs);

  always_comb begin
    fwd = FWD_RF;
    if (hit_m)      fwd = FWD_M;
    else if (hit_w) fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: forwarding, load-use and branch
// stall/flush, memory-wait stalling with timeout, and a stall-cycle counter.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  hz_state_t         state_reg, state_next;
  logic [4:0]        rd_m_reg, rd_w_reg;
  logic              reg_write_m_reg, reg_write_w_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              mem_err_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              mem_stall;
  logic              load_use;

  logic [4:0] rs_e [2];
  logic [1:0] fwd_sel [2];

  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_select u_fwd (
        .rs          (rs_e[gi]),
        .rd_m        (rd_m_reg),
        .reg_write_m (reg_write_m_reg),
        .rd_w        (rd_w_reg),
        .reg_write_w (reg_write_w_reg),
        .fwd         (fwd_sel[gi])
      );
    end
  endgenerate

  assign ForwardAE = fwd_sel[0];
  assign ForwardBE = fwd_sel[1];

  // Shadow of the M and W destination fields; a held M pushes a bubble into W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_m_reg        <= 5'd0;
      reg_write_m_reg <= 1'b0;
      rd_w_reg        <= 5'd0;
      reg_write_w_reg <= 1'b0;
    end else if (!StallM) begin
      rd_m_reg        <= RdE;
      reg_write_m_reg <= RegWriteE;
      rd_w_reg        <= rd_m_reg;
      reg_write_w_reg <= reg_write_m_reg;
    end else begin
      reg_write_w_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (MemReqM && !MemReadyM) state_next = MEM_WAIT;
      MEM_WAIT: if (MemReadyM)             state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  assign load_use = (ResultSrcE == RESULT_MEM) && RegWriteE && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // The memory stall overrides everything; a held branch flushes on release.
  always_comb begin
    mem_stall = ((state_reg == RUN) && MemReqM && !MemReadyM) ||
                ((state_reg == MEM_WAIT) && !MemReadyM);
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      FlushD = PCSrcE;
      FlushE = PCSrcE || load_use;
      StallF = load_use && !PCSrcE;
      StallD = load_use && !PCSrcE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      if (state_next == RUN)
        wait_cnt_reg <= '0;
      else if (state_reg == MEM_WAIT && wait_cnt_reg != WAIT_LIMIT)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      if (state_reg == MEM_WAIT && state_next == MEM_WAIT &&
          wait_cnt_reg + 1'b1 == WAIT_LIMIT)
        mem_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_reg <= '0;
    else if (StallF && stall_cnt_reg != {CNT_W{1'b1}})
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign mem_err      = mem_err_reg;
  assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MAX_WAIT = 4 and CNT_W = 4.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic       RegWriteE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       mem_err;
  logic [3:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RegWriteE    (RegWriteE),
    .ResultSrcE   (ResultSrcE),
    .PCSrcE       (PCSrcE),
    .MemReqM      (MemReqM),
    .MemReadyM    (MemReadyM),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] ctl;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clr_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    RegWriteE = 0; ResultSrcE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    cyc();
    clr_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    #3;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_fwd", {ForwardAE, ForwardBE}, 4'b0000);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_cnt", 32'(stall_cycles), 32'h0);
    #3;
    rst_n = 1'b1;

    // forwarding: x1 into M, then M and W, then x0 overtakes
    cyc();
    RdE = 5'd1; RegWriteE = 1'b1;
    cyc();
    Rs1E = 5'd1; Rs2E = 5'd2;
    #1;
    chk("fwd_m", ForwardAE, 2'b10);
    chk("fwd_b_none", ForwardBE, 2'b00);
    cyc(); #1;
    chk("fwd_mw", ForwardAE, 2'b10);
    RdE = 5'd0;
    cyc(); #1;
    chk("fwd_w_rdm0", ForwardAE, 2'b01);
    cyc(); #1;
    chk("fwd_rf_x0", ForwardAE, 2'b00);

    // load x5 in EX, ID reads x5 on Rs2
    rst_pulse();
    Rs2D = 5'd5; RdE = 5'd5; RegWriteE = 1'b1; ResultSrcE = 2'b01;
    #1;
    chk("lu_ctl", 32'(ctl), 32'b1100010);
    cyc();
    RdE = 5'd0; RegWriteE = 1'b0; ResultSrcE = 2'b00;
    #1;
    chk("lu_bubble_ctl", 32'(ctl), 32'h0);
    chk("lu_cnt", 32'(stall_cycles), 32'd1);
    cyc();
    Rs2D = 5'd0; Rs2E = 5'd5; RdE = 5'd6; RegWriteE = 1'b1;
    #1;
    chk("lu_fwd_w", ForwardBE, 2'b01);

    // load-use coinciding with a taken branch
    rst_pulse();
    Rs1D = 5'd5; RdE = 5'd5; RegWriteE = 1'b1; ResultSrcE = 2'b01; PCSrcE = 1'b1;
    #1;
    chk("lu_br_ctl", 32'(ctl), 32'b0000110);

    // three not-ready cycles with a branch held in EX
    rst_pulse();
    MemReqM = 1'b1; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_stall%0d", i), 32'(ctl), 32'b1111001);
      cyc();
    end
    MemReadyM = 1'b1;
    #1;
    chk("mw_release", 32'(ctl), 32'b0000110);
    cyc();
    MemReqM = 1'b0; MemReadyM = 1'b0; PCSrcE = 1'b0;
    #1;
    chk("mw_run_ctl", 32'(ctl), 32'h0);
    chk("mw_cnt", 32'(stall_cycles), 32'd3);
    chk("mw_no_err", 32'(mem_err), 32'h0);

    // timeout: ready never arrives
    rst_pulse();
    MemReqM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("to_err_low%0d", i), 32'(mem_err), 32'h0);
      cyc();
    end
    #1;
    chk("to_err_set", 32'(mem_err), 32'h1);
    MemReqM = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    #1;
    chk("to_err_sticky", 32'(mem_err), 32'h1);
    chk("to_still_stall", 32'(StallF), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("to_rst_err", 32'(mem_err), 32'h0);
    chk("to_rst_run", 32'(ctl), 32'h0);
    rst_n = 1'b1;

    // stall_cycles saturation
    rst_pulse();
    MemReqM = 1'b1;
    for (int i = 0; i < 14; i++) cyc();
    #1;
    chk("sat_14", 32'(stall_cycles), 32'd14);
    for (int i = 0; i < 6; i++) cyc();
    #1;
    chk("sat_15", 32'(stall_cycles), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
